seg_disp_arbiter: RTL and testbench

SEG_DISP_ARBITER -- requirements
Module: seg_disp_arbiter

---
 rtl/seg_disp_arbiter.sv | 124 ++++++++++++
 tb/tb_seg_disp_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_disp_arbiter.sv
// Round-robin arbiter that picks which of four sources owns the 8-digit hex display.
// Each grant reserves the display for HOLD_CYCLES clocks; freeze pauses the hold timer.
module seg_disp_arbiter #(
  parameter logic [31:0] HOLD_CYCLES = 32'd100_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [31:0] data0,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  input  logic [31:0] data3,
  input  logic        freeze,
  output logic [3:0]  ack,
  output logic [31:0] o_data,
  output logic [1:0]  o_src,
  output logic        o_valid
);

  // state | meaning
  // IDLE  | no active hold; any request may be granted
  // HOLD  | display reserved; cnt counts down to the next arbitration point
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [31:0] CNT_LOAD = HOLD_CYCLES - 32'd1;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [1:0]  last_q, last_d;
  logic [3:0]  ack_d;
  logic [31:0] o_data_d;
  logic [1:0]  o_src_d;
  logic        o_valid_d;

  logic [1:0]  winner;
  logic        win_found;
  logic [31:0] win_data;
  logic        cnt_zero;
  logic        eligible;

  // Search starts one past the last winner so every source gets its turn.
  always_comb begin
    winner    = last_q;
    win_found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (!win_found && req[last_q + 2'(k)]) begin
        winner    = last_q + 2'(k);
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    win_data = data0;
    case (winner)
      2'd0:    win_data = data0;
      2'd1:    win_data = data1;
      2'd2:    win_data = data2;
      default: win_data = data3;
    endcase
  end

  assign cnt_zero = (cnt_q == 32'd0);
  assign eligible = ((state_q == IDLE) || cnt_zero) && !freeze && win_found;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    ack_d     = 4'b0000;
    o_data_d  = o_data;
    o_src_d   = o_src;
    o_valid_d = o_valid;

    if (eligible) begin
      state_d   = HOLD;
      cnt_d     = CNT_LOAD;
      last_d    = winner;
      ack_d     = 4'b0001 << winner;
      o_data_d  = win_data;
      o_src_d   = winner;
      o_valid_d = 1'b1;
    end else begin
      case (state_q)
        HOLD: begin
          if (!freeze) begin
            if (!cnt_zero) begin
              cnt_d = cnt_q - 32'd1;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: begin
          cnt_d = 32'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 32'd0;
      last_q  <= 2'd3;
      ack     <= 4'b0000;
      o_data  <= 32'h0;
      o_src   <= 2'd0;
      o_valid <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      ack     <= ack_d;
      o_data  <= o_data_d;
      o_src   <= o_src_d;
      o_valid <= o_valid_d;
    end
  end

endmodule

// File: tb/tb_seg_disp_arbiter.sv
// Bench for seg_disp_arbiter: two instances (HOLD_CYCLES=4 and 1) driven by the same
// stimulus and compared every cycle against a behavioural display-ownership model.
module tb_seg_disp_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic        freeze;
  logic [31:0] data [4];

  logic [3:0]  ack_o   [2];
  logic [31:0] data_o  [2];
  logic [1:0]  src_o   [2];
  logic        valid_o [2];

  always #5 clk = ~clk;

  seg_disp_arbiter #(.HOLD_CYCLES(32'd4)) dut4 (
    .clk(clk), .rst(rst), .req(req),
    .data0(data[0]), .data1(data[1]), .data2(data[2]), .data3(data[3]),
    .freeze(freeze), .ack(ack_o[0]), .o_data(data_o[0]), .o_src(src_o[0]), .o_valid(valid_o[0])
  );

  seg_disp_arbiter #(.HOLD_CYCLES(32'd1)) dut1 (
    .clk(clk), .rst(rst), .req(req),
    .data0(data[0]), .data1(data[1]), .data2(data[2]), .data3(data[3]),
    .freeze(freeze), .ack(ack_o[1]), .o_data(data_o[1]), .o_src(src_o[1]), .o_valid(valid_o[1])
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ack_cyc[$];
  int ack_src[$];

  // model: who owns the display and how many more cycles until it can be re-arbitrated
  int unsigned hold_len [2] = '{4, 1};
  bit          m_busy   [2];
  int unsigned m_left   [2];
  int          m_last   [2];
  logic [31:0] m_data   [2];
  logic [1:0]  m_src    [2];
  logic [3:0]  m_ack    [2];
  logic        m_valid  [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 0; m_left[i] = 0; m_last[i] = 3;
      m_data[i] = 0; m_src[i] = 0; m_ack[i] = 0; m_valid[i] = 0;
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      bit can_grant;
      can_grant = (!m_busy[i] || m_left[i] == 0) && !freeze && (req != 0);
      m_ack[i] = 0;
      if (can_grant) begin
        int w;
        w = -1;
        for (int k = 1; k <= 4; k++)
          if (w < 0 && req[(m_last[i] + k) % 4]) w = (m_last[i] + k) % 4;
        m_data[i]  = data[w];
        m_src[i]   = w[1:0];
        m_ack[i]   = 4'(1 << w);
        m_last[i]  = w;
        m_valid[i] = 1;
        m_busy[i]  = 1;
        m_left[i]  = hold_len[i] - 1;
      end else if (m_busy[i] && !freeze) begin
        if (m_left[i] > 0) m_left[i]--;
        else m_busy[i] = 0;
      end
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("ack[h%0d]@%0d", hold_len[i], cyc),   ack_o[i],   m_ack[i]);
      chk($sformatf("data[h%0d]@%0d", hold_len[i], cyc),  data_o[i],  m_data[i]);
      chk($sformatf("src[h%0d]@%0d", hold_len[i], cyc),   src_o[i],   m_src[i]);
      chk($sformatf("valid[h%0d]@%0d", hold_len[i], cyc), valid_o[i], m_valid[i]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    check_all();
    if (ack_o[0] != 4'b0) begin
      ack_cyc.push_back(cyc);
      ack_src.push_back(int'(src_o[0]));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    check_all();
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] d_keep;
    rst = 1'b1; req = 4'b0; freeze = 1'b0;
    for (int i = 0; i < 4; i++) data[i] = 32'h0;
    model_reset();

    // outputs stay at reset values whatever req/freeze do
    repeat (3) begin
      req = 4'($urandom); freeze = 1'($urandom);
      for (int i = 0; i < 4; i++) data[i] = $urandom;
      step();
    end
    rst = 1'b0; req = 4'b0; freeze = 1'b0;
    step();

    // single request, one-cycle latency
    data[2] = 32'h1234_5678; req = 4'b0100;
    step();
    chk("single_ack", ack_o[0], 4'b0100);
    chk("single_data", data_o[0], 32'h1234_5678);
    chk("single_src", src_o[0], 2'd2);
    chk("single_valid", valid_o[0], 1'b1);
    req = 4'b0;
    repeat (6) step();
    chk("idle_keep_data", data_o[0], 32'h1234_5678);

    // all sources requesting: rotation 0,1,2,3,0 spaced by 4 cycles
    do_reset();
    ack_cyc.delete(); ack_src.delete();
    req = 4'b1111;
    repeat (17) step();
    chk("rr_count", ack_cyc.size(), 5);
    for (int k = 0; k < ack_src.size(); k++) chk($sformatf("rr_src%0d", k), ack_src[k], k % 4);
    for (int k = 1; k < ack_cyc.size(); k++) chk($sformatf("rr_gap%0d", k), ack_cyc[k] - ack_cyc[k-1], 4);
    req = 4'b0;
    repeat (5) step();

    // request raised and dropped inside a hold is lost
    do_reset();
    data[1] = $urandom; d_keep = data[1];
    req = 4'b0010;
    step();
    chk("drop_grant1", ack_o[0], 4'b0010);
    req = 4'b0; step();
    req = 4'b0001; step();
    req = 4'b0;
    ack_cyc.delete(); ack_src.delete();
    repeat (6) step();
    chk("drop_no_ack", ack_cyc.size(), 0);
    chk("drop_keep_data", data_o[0], d_keep);
    chk("drop_keep_src", src_o[0], 2'd1);

    // freeze for 3 cycles stretches the hold by exactly 3
    do_reset();
    data[0] = $urandom;
    ack_cyc.delete(); ack_src.delete();
    req = 4'b0001;
    step(); step();
    d_keep = data_o[0];
    freeze = 1'b1;
    repeat (3) begin
      data[0] = $urandom;
      step();
      chk("freeze_data_stable", data_o[0], d_keep);
    end
    freeze = 1'b0;
    repeat (6) step();
    chk("freeze_count", ack_cyc.size(), 2);
    if (ack_cyc.size() >= 2) chk("freeze_gap", ack_cyc[1] - ack_cyc[0], 7);

    // reset in the middle of a hold
    do_reset();
    data[3] = $urandom; req = 4'b1000;
    step();
    chk("rst_mid_grant3", ack_o[0], 4'b1000);
    req = 4'b0;
    step(); step();
    rst = 1'b1; model_reset();
    #1;
    chk("rst_mid_data", data_o[0], 32'h0);
    chk("rst_mid_valid", valid_o[0], 1'b0);
    chk("rst_mid_ack", ack_o[0], 4'b0);
    step();
    rst = 1'b0; req = 4'b1001; data[0] = $urandom;
    step();
    chk("rst_after_src", src_o[0], 2'd0);
    chk("rst_after_ack", ack_o[0], 4'b0001);
    req = 4'b0;
    repeat (4) step();

    // lone requester re-granted every hold period with fresh data
    do_reset();
    ack_cyc.delete(); ack_src.delete();
    req = 4'b1000;
    repeat (13) begin
      data[3] = $urandom;
      step();
    end
    chk("lone_count", ack_cyc.size(), 4);
    for (int k = 1; k < ack_cyc.size(); k++) chk($sformatf("lone_gap%0d", k), ack_cyc[k] - ack_cyc[k-1], 4);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      req = ($urandom_range(0, 3) == 0) ? 4'b0 : 4'($urandom);
      freeze = ($urandom_range(0, 9) == 0);
      for (int i = 0; i < 4; i++) data[i] = $urandom;
      rst = ($urandom_range(0, 99) == 0);
      if (rst) model_reset();
      step();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
